axi4_reg_slice: RTL and testbench

- Full AXI4 register slice, placed directly upstream of the AXI4-to-byte-enable-SRAM bridge, between an AXI4 initiator (master BFM or interconnect) and that bridge.
- Breaks every combinational path on all five channels (AW, W, B, AR, R): VALID, READY and payload are all driven from flops.
- Each channel is a 2-entry skid buffer, so sustained throughput is one beat per cycle with a fixed one-cycle added latency.
- Transparent to protocol: no reordering, merging or splitting of beats.

---
 rtl/axi4_reg_slice_pkg.sv | 25 ++
 rtl/axi4_skid_buffer.sv | 103 ++++++++++
 rtl/axi4_reg_slice.sv | 153 +++++++++++++++
 tb/tb_axi4_reg_slice.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_reg_slice_pkg.sv
// Shared types and field widths for the AXI4 register slice.
package axi4_reg_slice_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int AXI_LEN_W    = 8;
  localparam int AXI_RESP_W   = 2;
  localparam int AXI_SIZE_W   = 3;
  localparam int AXI_BURST_W  = 2;
  localparam int AXI_CACHE_W  = 4;
  localparam int AXI_PROT_W   = 3;
  localparam int AXI_QOS_W    = 4;
  localparam int AXI_REGION_W = 4;

  // Width of a packed AW/AR payload: address, id, and all burst/attribute fields.
  function automatic int ax_payload_width(input int addr_w, input int id_w);
    return addr_w + id_w + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W + 1 +
           AXI_CACHE_W + AXI_PROT_W + AXI_QOS_W + AXI_REGION_W;
  endfunction

endpackage

// File: rtl/axi4_skid_buffer.sv
// Two-entry skid buffer: every output (in_ready, out_valid, out_data) comes
// straight from a flop, so no combinational path crosses the buffer.
module axi4_skid_buffer
  import axi4_reg_slice_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_e      state;
  skid_state_e      next_state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;

  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // Occupancy transitions and the register load enables they imply.
  always_comb begin
    next_state    = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          next_state = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (push && pop) begin
          load_out = 1'b1;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          next_state    = ONE;
          out_from_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // State plus registered READY/VALID; both handshake flags stay low in reset
  // and READY first rises on the edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      in_ready_q  <= (next_state != FULL);
      out_valid_q <= (next_state != EMPTY);
    end
  end

  // Output register: fresh beat when empty/streaming, or refill from the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (load_out) begin
      out_q <= in_data;
    end else if (out_from_skid) begin
      out_q <= skid_q;
    end
  end

  // Skid register catches the beat accepted while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

endmodule

// File: rtl/axi4_reg_slice.sv
// Full AXI4 register slice: one skid buffer per channel; this level only
// packs and unpacks channel fields.
module axi4_reg_slice
  import axi4_reg_slice_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 32,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // Target side (from the initiator BFM / interconnect)
  input  logic [AXI_ADDRESS_WIDTH-1:0]  t_AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]       t_AWID,
  input  logic [AXI_LEN_W-1:0]          t_AWLEN,
  input  logic [AXI_SIZE_W-1:0]         t_AWSIZE,
  input  logic [AXI_BURST_W-1:0]        t_AWBURST,
  input  logic                          t_AWLOCK,
  input  logic [AXI_CACHE_W-1:0]        t_AWCACHE,
  input  logic [AXI_PROT_W-1:0]         t_AWPROT,
  input  logic [AXI_QOS_W-1:0]          t_AWQOS,
  input  logic [AXI_REGION_W-1:0]       t_AWREGION,
  input  logic                          t_AWVALID,
  output logic                          t_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     t_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   t_WSTRB,
  input  logic                          t_WLAST,
  input  logic                          t_WVALID,
  output logic                          t_WREADY,
  output logic [AXI_ID_WIDTH-1:0]       t_BID,
  output logic [AXI_RESP_W-1:0]         t_BRESP,
  output logic                          t_BVALID,
  input  logic                          t_BREADY,
  input  logic [AXI_ADDRESS_WIDTH-1:0]  t_ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]       t_ARID,
  input  logic [AXI_LEN_W-1:0]          t_ARLEN,
  input  logic [AXI_SIZE_W-1:0]         t_ARSIZE,
  input  logic [AXI_BURST_W-1:0]        t_ARBURST,
  input  logic                          t_ARLOCK,
  input  logic [AXI_CACHE_W-1:0]        t_ARCACHE,
  input  logic [AXI_PROT_W-1:0]         t_ARPROT,
  input  logic [AXI_QOS_W-1:0]          t_ARQOS,
  input  logic [AXI_REGION_W-1:0]       t_ARREGION,
  input  logic                          t_ARVALID,
  output logic                          t_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]     t_RDATA,
  output logic [AXI_ID_WIDTH-1:0]       t_RID,
  output logic [AXI_RESP_W-1:0]         t_RRESP,
  output logic                          t_RLAST,
  output logic                          t_RVALID,
  input  logic                          t_RREADY,
  // Initiator side (toward the SRAM bridge)
  output logic [AXI_ADDRESS_WIDTH-1:0]  i_AWADDR,
  output logic [AXI_ID_WIDTH-1:0]       i_AWID,
  output logic [AXI_LEN_W-1:0]          i_AWLEN,
  output logic [AXI_SIZE_W-1:0]         i_AWSIZE,
  output logic [AXI_BURST_W-1:0]        i_AWBURST,
  output logic                          i_AWLOCK,
  output logic [AXI_CACHE_W-1:0]        i_AWCACHE,
  output logic [AXI_PROT_W-1:0]         i_AWPROT,
  output logic [AXI_QOS_W-1:0]          i_AWQOS,
  output logic [AXI_REGION_W-1:0]       i_AWREGION,
  output logic                          i_AWVALID,
  input  logic                          i_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     i_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   i_WSTRB,
  output logic                          i_WLAST,
  output logic                          i_WVALID,
  input  logic                          i_WREADY,
  input  logic [AXI_ID_WIDTH-1:0]       i_BID,
  input  logic [AXI_RESP_W-1:0]         i_BRESP,
  input  logic                          i_BVALID,
  output logic                          i_BREADY,
  output logic [AXI_ADDRESS_WIDTH-1:0]  i_ARADDR,
  output logic [AXI_ID_WIDTH-1:0]       i_ARID,
  output logic [AXI_LEN_W-1:0]          i_ARLEN,
  output logic [AXI_SIZE_W-1:0]         i_ARSIZE,
  output logic [AXI_BURST_W-1:0]        i_ARBURST,
  output logic                          i_ARLOCK,
  output logic [AXI_CACHE_W-1:0]        i_ARCACHE,
  output logic [AXI_PROT_W-1:0]         i_ARPROT,
  output logic [AXI_QOS_W-1:0]          i_ARQOS,
  output logic [AXI_REGION_W-1:0]       i_ARREGION,
  output logic                          i_ARVALID,
  input  logic                          i_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     i_RDATA,
  input  logic [AXI_ID_WIDTH-1:0]       i_RID,
  input  logic [AXI_RESP_W-1:0]         i_RRESP,
  input  logic                          i_RLAST,
  input  logic                          i_RVALID,
  output logic                          i_RREADY
);

  localparam int AX_W = ax_payload_width(AXI_ADDRESS_WIDTH, AXI_ID_WIDTH);
  localparam int W_W  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1;
  localparam int B_W  = AXI_ID_WIDTH + AXI_RESP_W;
  localparam int R_W  = AXI_DATA_WIDTH + AXI_ID_WIDTH + AXI_RESP_W + 1;

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  assign aw_in = {t_AWADDR, t_AWID, t_AWLEN, t_AWSIZE, t_AWBURST, t_AWLOCK,
                  t_AWCACHE, t_AWPROT, t_AWQOS, t_AWREGION};
  assign {i_AWADDR, i_AWID, i_AWLEN, i_AWSIZE, i_AWBURST, i_AWLOCK,
          i_AWCACHE, i_AWPROT, i_AWQOS, i_AWREGION} = aw_out;

  assign w_in = {t_WDATA, t_WSTRB, t_WLAST};
  assign {i_WDATA, i_WSTRB, i_WLAST} = w_out;

  assign b_in = {i_BID, i_BRESP};
  assign {t_BID, t_BRESP} = b_out;

  assign ar_in = {t_ARADDR, t_ARID, t_ARLEN, t_ARSIZE, t_ARBURST, t_ARLOCK,
                  t_ARCACHE, t_ARPROT, t_ARQOS, t_ARREGION};
  assign {i_ARADDR, i_ARID, i_ARLEN, i_ARSIZE, i_ARBURST, i_ARLOCK,
          i_ARCACHE, i_ARPROT, i_ARQOS, i_ARREGION} = ar_out;

  assign r_in = {i_RDATA, i_RID, i_RRESP, i_RLAST};
  assign {t_RDATA, t_RID, t_RRESP, t_RLAST} = r_out;

  axi4_skid_buffer #(.WIDTH(AX_W)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(t_AWVALID), .in_ready(t_AWREADY), .in_data(aw_in),
    .out_valid(i_AWVALID), .out_ready(i_AWREADY), .out_data(aw_out)
  );

  axi4_skid_buffer #(.WIDTH(W_W)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(t_WVALID), .in_ready(t_WREADY), .in_data(w_in),
    .out_valid(i_WVALID), .out_ready(i_WREADY), .out_data(w_out)
  );

  axi4_skid_buffer #(.WIDTH(B_W)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(i_BVALID), .in_ready(i_BREADY), .in_data(b_in),
    .out_valid(t_BVALID), .out_ready(t_BREADY), .out_data(b_out)
  );

  axi4_skid_buffer #(.WIDTH(AX_W)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(t_ARVALID), .in_ready(t_ARREADY), .in_data(ar_in),
    .out_valid(i_ARVALID), .out_ready(i_ARREADY), .out_data(ar_out)
  );

  axi4_skid_buffer #(.WIDTH(R_W)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(i_RVALID), .in_ready(i_RREADY), .in_data(r_in),
    .out_valid(t_RVALID), .out_ready(t_RREADY), .out_data(r_out)
  );

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Directed and randomized checks of the AXI4 register slice.
module tb_axi4_reg_slice;

  localparam int A = 32;
  localparam int D = 32;
  localparam int I = 4;
  localparam int S = D / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [A-1:0] t_AWADDR, i_AWADDR, t_ARADDR, i_ARADDR;
  logic [I-1:0] t_AWID, i_AWID, t_ARID, i_ARID, t_BID, i_BID, t_RID, i_RID;
  logic [7:0]   t_AWLEN, i_AWLEN, t_ARLEN, i_ARLEN;
  logic [2:0]   t_AWSIZE, i_AWSIZE, t_ARSIZE, i_ARSIZE, t_AWPROT, i_AWPROT, t_ARPROT, i_ARPROT;
  logic [1:0]   t_AWBURST, i_AWBURST, t_ARBURST, i_ARBURST;
  logic         t_AWLOCK, i_AWLOCK, t_ARLOCK, i_ARLOCK;
  logic [3:0]   t_AWCACHE, i_AWCACHE, t_ARCACHE, i_ARCACHE, t_AWQOS, i_AWQOS, t_ARQOS, i_ARQOS;
  logic [3:0]   t_AWREGION, i_AWREGION, t_ARREGION, i_ARREGION;
  logic         t_AWVALID, t_AWREADY, i_AWVALID, i_AWREADY;
  logic         t_ARVALID, t_ARREADY, i_ARVALID, i_ARREADY;
  logic [D-1:0] t_WDATA, i_WDATA, t_RDATA, i_RDATA;
  logic [S-1:0] t_WSTRB, i_WSTRB;
  logic         t_WLAST, i_WLAST, t_WVALID, t_WREADY, i_WVALID, i_WREADY;
  logic [1:0]   t_BRESP, i_BRESP, t_RRESP, i_RRESP;
  logic         t_BVALID, t_BREADY, i_BVALID, i_BREADY;
  logic         t_RLAST, i_RLAST, t_RVALID, t_RREADY, i_RVALID, i_RREADY;

  logic [9:0] hs_outs;
  assign hs_outs = {t_AWREADY, t_WREADY, t_ARREADY, i_BREADY, i_RREADY,
                    i_AWVALID, i_WVALID, i_ARVALID, t_BVALID, t_RVALID};

  int tests = 0;
  int fails = 0;

  axi4_reg_slice #(.AXI_ADDRESS_WIDTH(A), .AXI_DATA_WIDTH(D), .AXI_ID_WIDTH(I)) dut (
    .clk(clk), .rst(rst),
    .t_AWADDR(t_AWADDR), .t_AWID(t_AWID), .t_AWLEN(t_AWLEN), .t_AWSIZE(t_AWSIZE),
    .t_AWBURST(t_AWBURST), .t_AWLOCK(t_AWLOCK), .t_AWCACHE(t_AWCACHE), .t_AWPROT(t_AWPROT),
    .t_AWQOS(t_AWQOS), .t_AWREGION(t_AWREGION), .t_AWVALID(t_AWVALID), .t_AWREADY(t_AWREADY),
    .t_WDATA(t_WDATA), .t_WSTRB(t_WSTRB), .t_WLAST(t_WLAST), .t_WVALID(t_WVALID), .t_WREADY(t_WREADY),
    .t_BID(t_BID), .t_BRESP(t_BRESP), .t_BVALID(t_BVALID), .t_BREADY(t_BREADY),
    .t_ARADDR(t_ARADDR), .t_ARID(t_ARID), .t_ARLEN(t_ARLEN), .t_ARSIZE(t_ARSIZE),
    .t_ARBURST(t_ARBURST), .t_ARLOCK(t_ARLOCK), .t_ARCACHE(t_ARCACHE), .t_ARPROT(t_ARPROT),
    .t_ARQOS(t_ARQOS), .t_ARREGION(t_ARREGION), .t_ARVALID(t_ARVALID), .t_ARREADY(t_ARREADY),
    .t_RDATA(t_RDATA), .t_RID(t_RID), .t_RRESP(t_RRESP), .t_RLAST(t_RLAST), .t_RVALID(t_RVALID),
    .t_RREADY(t_RREADY),
    .i_AWADDR(i_AWADDR), .i_AWID(i_AWID), .i_AWLEN(i_AWLEN), .i_AWSIZE(i_AWSIZE),
    .i_AWBURST(i_AWBURST), .i_AWLOCK(i_AWLOCK), .i_AWCACHE(i_AWCACHE), .i_AWPROT(i_AWPROT),
    .i_AWQOS(i_AWQOS), .i_AWREGION(i_AWREGION), .i_AWVALID(i_AWVALID), .i_AWREADY(i_AWREADY),
    .i_WDATA(i_WDATA), .i_WSTRB(i_WSTRB), .i_WLAST(i_WLAST), .i_WVALID(i_WVALID), .i_WREADY(i_WREADY),
    .i_BID(i_BID), .i_BRESP(i_BRESP), .i_BVALID(i_BVALID), .i_BREADY(i_BREADY),
    .i_ARADDR(i_ARADDR), .i_ARID(i_ARID), .i_ARLEN(i_ARLEN), .i_ARSIZE(i_ARSIZE),
    .i_ARBURST(i_ARBURST), .i_ARLOCK(i_ARLOCK), .i_ARCACHE(i_ARCACHE), .i_ARPROT(i_ARPROT),
    .i_ARQOS(i_ARQOS), .i_ARREGION(i_ARREGION), .i_ARVALID(i_ARVALID), .i_ARREADY(i_ARREADY),
    .i_RDATA(i_RDATA), .i_RID(i_RID), .i_RRESP(i_RRESP), .i_RLAST(i_RLAST), .i_RVALID(i_RVALID),
    .i_RREADY(i_RREADY)
  );

  always #5 clk = ~clk;

  task automatic init_inputs();
    t_AWADDR = '0; t_AWID = '0; t_AWLEN = '0; t_AWSIZE = '0; t_AWBURST = '0; t_AWLOCK = 1'b0;
    t_AWCACHE = '0; t_AWPROT = '0; t_AWQOS = '0; t_AWREGION = '0; t_AWVALID = 1'b0;
    t_ARADDR = '0; t_ARID = '0; t_ARLEN = '0; t_ARSIZE = '0; t_ARBURST = '0; t_ARLOCK = 1'b0;
    t_ARCACHE = '0; t_ARPROT = '0; t_ARQOS = '0; t_ARREGION = '0; t_ARVALID = 1'b0;
    t_WDATA = '0; t_WSTRB = '0; t_WLAST = 1'b0; t_WVALID = 1'b0;
    t_BREADY = 1'b0; t_RREADY = 1'b0;
    i_AWREADY = 1'b0; i_WREADY = 1'b0; i_ARREADY = 1'b0;
    i_BID = '0; i_BRESP = '0; i_BVALID = 1'b0;
    i_RDATA = '0; i_RID = '0; i_RRESP = '0; i_RLAST = 1'b0; i_RVALID = 1'b0;
  endtask

  // Reset holds every handshake output low; READY rises one edge after release.
  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (hs_outs !== 10'b0) begin
      fails++; $display("[TB] FAIL reset_hs: got %b want %b", hs_outs, 10'b0);
    end
    tests++;
    if ({i_AWADDR, i_WDATA, t_RDATA} !== '0) begin
      fails++; $display("[TB] FAIL reset_payload: got %h/%h/%h want 0", i_AWADDR, i_WDATA, t_RDATA);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if (hs_outs !== 10'b0) begin
      fails++; $display("[TB] FAIL release_pre_edge: got %b want %b", hs_outs, 10'b0);
    end
    @(posedge clk);
    #1;
    tests++;
    if (hs_outs !== 10'b11111_00000) begin
      fails++; $display("[TB] FAIL release_ready: got %b want %b", hs_outs, 10'b11111_00000);
    end
  endtask

  // One AR beat appears on the initiator side exactly one cycle after handshake.
  task automatic test_single_ar();
    @(posedge clk);
    #1;
    i_ARREADY = 1'b1;
    t_ARVALID = 1'b1; t_ARADDR = 32'h100; t_ARLEN = 8'd3; t_ARID = 4'd5;
    t_ARSIZE = 3'd2; t_ARBURST = 2'b01; t_ARCACHE = 4'h3; t_ARPROT = 3'd2;
    t_ARQOS = 4'h9; t_ARREGION = 4'hA;
    @(negedge clk);
    tests++;
    if ({t_ARREADY, i_ARVALID} !== 2'b10) begin
      fails++; $display("[TB] FAIL ar_pre: got rdy/vld %b want 10", {t_ARREADY, i_ARVALID});
    end
    @(posedge clk);
    #1;
    t_ARVALID = 1'b0;
    tests++;
    if ({i_ARVALID, i_ARADDR, i_ARLEN, i_ARID, i_ARSIZE, i_ARBURST, i_ARCACHE, i_ARPROT, i_ARQOS, i_ARREGION}
        !== {1'b1, 32'h100, 8'd3, 4'd5, 3'd2, 2'b01, 4'h3, 3'd2, 4'h9, 4'hA}) begin
      fails++; $display("[TB] FAIL ar_out: got vld=%b addr=%h len=%0d id=%0d want vld=1 addr=100 len=3 id=5",
                        i_ARVALID, i_ARADDR, i_ARLEN, i_ARID);
    end
    @(posedge clk);
    #1;
    tests++;
    if (i_ARVALID !== 1'b0) begin
      fails++; $display("[TB] FAIL ar_gone: got vld=%b want 0", i_ARVALID);
    end
    i_ARREADY = 1'b0;
  endtask

  // Sixteen W beats stream through with no bubbles; LAST only on the final beat.
  task automatic test_w_burst();
    logic [D+S:0] expv;
    logic [D+S:0] gotv;
    @(posedge clk);
    #1;
    i_WREADY = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k >= 1) begin
        expv = {1'b1, 32'hA000_0000 + 32'(k - 1), 4'hF ^ 4'(k - 1), (k == 16)};
        gotv = {i_WVALID, i_WDATA, i_WSTRB, i_WLAST};
        tests++;
        if (gotv !== expv) begin
          fails++; $display("[TB] FAIL w_beat%0d: got %h want %h", k - 1, gotv, expv);
        end
      end
      if (k < 16) begin
        tests++;
        if (t_WREADY !== 1'b1) begin
          fails++; $display("[TB] FAIL w_ready%0d: got %b want 1", k, t_WREADY);
        end
        t_WVALID = 1'b1;
        t_WDATA  = 32'hA000_0000 + 32'(k);
        t_WSTRB  = 4'hF ^ 4'(k);
        t_WLAST  = (k == 15);
      end else begin
        t_WVALID = 1'b0;
        t_WLAST  = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (i_WVALID !== 1'b0) begin
      fails++; $display("[TB] FAIL w_after: got vld=%b want 0", i_WVALID);
    end
    i_WREADY = 1'b0;
  endtask

  // Stalled R consumer: buffer fills, READY drops, data holds, then drains in order.
  task automatic test_r_stall();
    logic [D-1:0] beats [3];
    logic [D-1:0] hold;
    int prod;
    int cons;
    bit stalled;
    beats[0] = 32'h1111_0001; beats[1] = 32'h2222_0002; beats[2] = 32'h3333_0003;
    prod = 0; cons = 0; stalled = 1'b0; hold = '0;
    @(posedge clk);
    #1;
    t_RREADY = 1'b0;
    for (int c = 0; c < 20; c++) begin
      i_RVALID = (prod < 3);
      i_RDATA  = (prod < 3) ? beats[prod] : '0;
      i_RID    = 4'(prod + 1);
      i_RLAST  = (prod == 2);
      t_RREADY = (c >= 6);
      @(negedge clk);
      if (c == 3) begin
        tests++;
        if ({i_RREADY, t_RVALID} !== 2'b01) begin
          fails++; $display("[TB] FAIL r_full: got rdy/vld %b want 01", {i_RREADY, t_RVALID});
        end
      end
      if (stalled) begin
        tests++;
        if ({t_RVALID, t_RDATA} !== {1'b1, hold}) begin
          fails++; $display("[TB] FAIL r_stable: got vld=%b data=%h want 1/%h", t_RVALID, t_RDATA, hold);
        end
      end
      if (i_RVALID && i_RREADY) prod++;
      if (t_RVALID && t_RREADY) begin
        tests++;
        if (cons > 2 || {t_RDATA, t_RID, t_RLAST} !== {beats[cons], 4'(cons + 1), (cons == 2)}) begin
          fails++; $display("[TB] FAIL r_order%0d: got data=%h id=%0d last=%b", cons, t_RDATA, t_RID, t_RLAST);
        end
        cons++;
      end
      stalled = t_RVALID && !t_RREADY;
      hold = t_RDATA;
      @(posedge clk);
      #1;
    end
    i_RVALID = 1'b0;
    tests++;
    if (cons !== 3) begin
      fails++; $display("[TB] FAIL r_count: got %0d beats want 3", cons);
    end
    t_RREADY = 1'b0;
  endtask

  // Random VALID/READY on W (forward) and R (reverse) against scoreboards.
  task automatic test_random();
    logic [D+S:0]   wq [$];
    logic [D+I+2:0] rq [$];
    logic [D+S:0]   wgot, wexp, whold;
    logic [D+I+2:0] rgot, rexp, rhold;
    bit wst, rst_stall, wdone, rdone;
    int wsent, rsent;
    wst = 0; rst_stall = 0; wsent = 0; rsent = 0; whold = '0; rhold = '0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2030; c++) begin
      @(negedge clk);
      wgot = {i_WDATA, i_WSTRB, i_WLAST};
      rgot = {t_RDATA, t_RID, t_RRESP, t_RLAST};
      wdone = t_WVALID && t_WREADY;
      rdone = i_RVALID && i_RREADY;
      if (wdone) begin wq.push_back({t_WDATA, t_WSTRB, t_WLAST}); wsent++; end
      if (rdone) begin rq.push_back({i_RDATA, i_RID, i_RRESP, i_RLAST}); rsent++; end
      if (wst) begin
        tests++;
        if (!i_WVALID || wgot !== whold) begin
          fails++; $display("[TB] FAIL rnd_w_stable: got %b/%h want 1/%h", i_WVALID, wgot, whold);
        end
      end
      if (rst_stall) begin
        tests++;
        if (!t_RVALID || rgot !== rhold) begin
          fails++; $display("[TB] FAIL rnd_r_stable: got %b/%h want 1/%h", t_RVALID, rgot, rhold);
        end
      end
      if (i_WVALID && i_WREADY) begin
        tests++;
        wexp = (wq.size() > 0) ? wq.pop_front() : ~wgot;
        if (wgot !== wexp) begin
          fails++; $display("[TB] FAIL rnd_w_beat: got %h want %h", wgot, wexp);
        end
      end
      if (t_RVALID && t_RREADY) begin
        tests++;
        rexp = (rq.size() > 0) ? rq.pop_front() : ~rgot;
        if (rgot !== rexp) begin
          fails++; $display("[TB] FAIL rnd_r_beat: got %h want %h", rgot, rexp);
        end
      end
      wst = i_WVALID && !i_WREADY; whold = wgot;
      rst_stall = t_RVALID && !t_RREADY; rhold = rgot;
      @(posedge clk);
      #1;
      if (c < 2000) begin
        if (!t_WVALID || wdone) begin
          t_WVALID = 1'($urandom_range(0, 1));
          t_WDATA = $urandom; t_WSTRB = 4'($urandom); t_WLAST = 1'($urandom);
        end
        if (!i_RVALID || rdone) begin
          i_RVALID = 1'($urandom_range(0, 1));
          i_RDATA = $urandom; i_RID = 4'($urandom); i_RRESP = 2'($urandom); i_RLAST = 1'($urandom);
        end
        i_WREADY = 1'($urandom_range(0, 1));
        t_RREADY = 1'($urandom_range(0, 1));
      end else begin
        if (wdone) t_WVALID = 1'b0;
        if (rdone) i_RVALID = 1'b0;
        if (c >= 2010) begin t_WVALID = 1'b0; i_RVALID = 1'b0; end
        i_WREADY = 1'b1;
        t_RREADY = 1'b1;
      end
    end
    tests++;
    if (wq.size() != 0 || rq.size() != 0) begin
      fails++; $display("[TB] FAIL rnd_drain: got %0d/%0d pending want 0/0", wq.size(), rq.size());
    end
    tests++;
    if (wsent < 100 || rsent < 100) begin
      fails++; $display("[TB] FAIL rnd_traffic: got %0d/%0d beats want >=100", wsent, rsent);
    end
    i_WREADY = 1'b0; t_RREADY = 1'b0;
  endtask

  // Asynchronous reset with AW full and a B beat buffered discards everything.
  task automatic test_reset_midstream();
    @(posedge clk);
    #1;
    i_AWREADY = 1'b0; t_BREADY = 1'b0;
    t_AWVALID = 1'b1; t_AWADDR = 32'hDEAD_0000; t_AWID = 4'd1;
    i_BVALID = 1'b1; i_BID = 4'd7; i_BRESP = 2'b10;
    @(posedge clk);
    #1;
    i_BVALID = 1'b0;
    t_AWADDR = 32'hDEAD_0004; t_AWID = 4'd2;
    @(posedge clk);
    #1;
    t_AWVALID = 1'b0;
    tests++;
    if ({t_AWREADY, i_AWVALID, t_BVALID, t_BID, t_BRESP} !== {1'b0, 1'b1, 1'b1, 4'd7, 2'b10}) begin
      fails++; $display("[TB] FAIL mid_full: got awrdy=%b awvld=%b bvld=%b bid=%0d bresp=%b",
                        t_AWREADY, i_AWVALID, t_BVALID, t_BID, t_BRESP);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (hs_outs !== 10'b0) begin
      fails++; $display("[TB] FAIL mid_async: got %b want %b", hs_outs, 10'b0);
    end
    tests++;
    if ({i_AWADDR, t_BID, t_BRESP} !== '0) begin
      fails++; $display("[TB] FAIL mid_payload: got addr=%h bid=%0d bresp=%b want 0", i_AWADDR, t_BID, t_BRESP);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (hs_outs !== 10'b0) begin
      fails++; $display("[TB] FAIL mid_release_pre: got %b want %b", hs_outs, 10'b0);
    end
    @(posedge clk);
    #1;
    tests++;
    if (hs_outs !== 10'b11111_00000) begin
      fails++; $display("[TB] FAIL mid_release: got %b want %b", hs_outs, 10'b11111_00000);
    end
  endtask

  // Exclusive AR/AW pair through the slice; a small bridge model answers EXOKAY.
  task automatic test_exclusive();
    logic [A-1:0] ar_addr, aw_addr;
    logic [I-1:0] ar_id, aw_id;
    logic ar_lock, aw_lock, seen, wlast_seen;
    ar_addr = '0; aw_addr = '0; ar_id = '0; aw_id = '0; ar_lock = 0; aw_lock = 0;
    @(posedge clk);
    #1;
    i_ARREADY = 1'b1; i_AWREADY = 1'b1; i_WREADY = 1'b1; t_BREADY = 1'b1;
    t_ARVALID = 1'b1; t_ARADDR = 32'h200; t_ARID = 4'd3; t_ARLOCK = 1'b1; t_ARLEN = 8'd0;
    @(posedge clk);
    #1;
    t_ARVALID = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (i_ARVALID) begin seen = 1'b1; ar_addr = i_ARADDR; ar_id = i_ARID; ar_lock = i_ARLOCK; end
    end
    tests++;
    if ({seen, ar_lock, ar_addr, ar_id} !== {1'b1, 1'b1, 32'h200, 4'd3}) begin
      fails++; $display("[TB] FAIL excl_ar: got seen=%b lock=%b addr=%h id=%0d want 1/1/200/3",
                        seen, ar_lock, ar_addr, ar_id);
    end
    @(posedge clk);
    #1;
    t_AWVALID = 1'b1; t_AWADDR = 32'h200; t_AWID = 4'd3; t_AWLOCK = 1'b1; t_AWLEN = 8'd0;
    t_WVALID = 1'b1; t_WDATA = 32'hCAFE_F00D; t_WSTRB = 4'hF; t_WLAST = 1'b1;
    @(posedge clk);
    #1;
    t_AWVALID = 1'b0; t_WVALID = 1'b0; t_WLAST = 1'b0;
    seen = 1'b0; wlast_seen = 1'b0;
    for (int k = 0; k < 10 && !(seen && wlast_seen); k++) begin
      @(negedge clk);
      if (i_AWVALID) begin seen = 1'b1; aw_addr = i_AWADDR; aw_id = i_AWID; aw_lock = i_AWLOCK; end
      if (i_WVALID && i_WLAST) wlast_seen = 1'b1;
    end
    tests++;
    if ({seen, wlast_seen, aw_lock} !== 3'b111) begin
      fails++; $display("[TB] FAIL excl_aw: got aw=%b wlast=%b lock=%b want 111", seen, wlast_seen, aw_lock);
    end
    @(posedge clk);
    #1;
    i_BVALID = 1'b1;
    i_BID    = aw_id;
    i_BRESP  = (ar_lock && aw_lock && ar_addr == aw_addr && ar_id == aw_id) ? 2'b01 : 2'b00;
    @(posedge clk);
    #1;
    i_BVALID = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (t_BVALID) begin
        seen = 1'b1;
        tests++;
        if ({t_BID, t_BRESP} !== {4'd3, 2'b01}) begin
          fails++; $display("[TB] FAIL excl_b: got id=%0d resp=%b want 3/01", t_BID, t_BRESP);
        end
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("[TB] FAIL excl_b_timeout: got no BVALID want BVALID within 10 cycles");
    end
    @(posedge clk);
    #1;
    init_inputs();
  endtask

  initial begin
    test_reset();
    test_single_ar();
    test_w_burst();
    test_r_stall();
    test_random();
    test_reset_midstream();
    test_exclusive();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
